fifo_addr_ctrl: RTL

- Shared FIFO address generator that drives the counter side of the shared FIFO controller interface.
- Consumes the per-stage enable vector, which is already OR-reduced across all NTT/INTT clients. Stages are indexed in INTT order; NTT clients see the stage order reversed.
- Produces one circular write/read address per butterfly-stage delay FIFO, plus the multiplier-stage FIFO address.
- Tracks whether each FIFO has been filled once since reset/flush, so clients can qualify output data.

---
 rtl/fifo_addr_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_addr_ctrl.sv
// Circular address generator for the shared NTT/INTT delay FIFOs and the multiplier FIFO.
// One registered wrap-around counter per FIFO, plus a sticky "wrapped once" flag.
module fifo_addr_ctrl #(
  parameter int unsigned NTT_STAGE_CNT = 8,
  parameter int unsigned MUL_STAGE_CNT = 4,
  localparam int unsigned MAX_HRS  = 1 << (NTT_STAGE_CNT - 2),
  localparam int unsigned FIFO2_AW =
      $clog2((MAX_HRS > MUL_STAGE_CNT) ? MAX_HRS : MUL_STAGE_CNT),
  localparam int unsigned MUL_AW   = $clog2(MUL_STAGE_CNT - 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [NTT_STAGE_CNT-1:0]          en,
  input  logic                              mul_en,
  output logic [NTT_STAGE_CNT*FIFO2_AW-1:0] fifo2_addr,
  output logic [MUL_AW-1:0]                 fifom_addr,
  output logic [NTT_STAGE_CNT-1:0]          primed,
  output logic                              fifom_primed
);

  if (NTT_STAGE_CNT < 3 || MUL_STAGE_CNT < 3) begin : gen_bad_cnt
    $fatal(1, "fifo_addr_ctrl: NTT_STAGE_CNT and MUL_STAGE_CNT must both be >= 3");
  end

  if (((MAX_HRS - 1) >> FIFO2_AW) != 0) begin : gen_bad_aw
    $fatal(1, "fifo_addr_ctrl: FIFO2_AW too narrow for MAX_HRS-1");
  end

  // Halving depth per stage, floored at 1 for the last stages.
  function automatic int unsigned stage_depth(int unsigned idx);
    int unsigned d;
    d = MAX_HRS >> idx;
    return (d == 0) ? 1 : d;
  endfunction

  for (genvar i = 0; i < NTT_STAGE_CNT; i++) begin : gen_stage
    localparam int unsigned Depth = stage_depth(i);
    localparam logic [FIFO2_AW-1:0] Last = FIFO2_AW'(Depth - 1);

    logic [FIFO2_AW-1:0] addr_q, addr_d;
    logic                primed_q, primed_d;

    // Depth-1 stages have Last == 0, so every enable is a wrap.
    always_comb begin
      addr_d   = addr_q;
      primed_d = primed_q;
      if (en[i]) begin
        if (addr_q == Last) begin
          addr_d   = '0;
          primed_d = 1'b1;
        end else begin
          addr_d = addr_q + FIFO2_AW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        addr_q   <= '0;
        primed_q <= 1'b0;
      end else begin
        addr_q   <= addr_d;
        primed_q <= primed_d;
      end
    end

    assign fifo2_addr[i*FIFO2_AW +: FIFO2_AW] = addr_q;
    assign primed[i]                          = primed_q;
  end

  localparam logic [MUL_AW-1:0] MulLast = MUL_AW'(MUL_STAGE_CNT - 2);

  logic [MUL_AW-1:0] mul_addr_q, mul_addr_d;
  logic              mul_primed_q, mul_primed_d;

  always_comb begin
    mul_addr_d   = mul_addr_q;
    mul_primed_d = mul_primed_q;
    if (mul_en) begin
      if (mul_addr_q == MulLast) begin
        mul_addr_d   = '0;
        mul_primed_d = 1'b1;
      end else begin
        mul_addr_d = mul_addr_q + MUL_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mul_addr_q   <= '0;
      mul_primed_q <= 1'b0;
    end else begin
      mul_addr_q   <= mul_addr_d;
      mul_primed_q <= mul_primed_d;
    end
  end

  assign fifom_addr   = mul_addr_q;
  assign fifom_primed = mul_primed_q;

endmodule
